// File: rtl/coriolis_pkg.sv
// Shared types and constants for the coriolis kernel output stages.
package coriolis_pkg;

  localparam int unsigned STREAMW_DEFAULT = 34;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ostream_state_t;

endpackage

// File: rtl/coriolis_sync_fifo.sv
// Synchronous first-word fall-through FIFO with registered storage and
// full/empty flags; synchronous active-low reset flushes it.
module coriolis_sync_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == CW'(0));
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end

endmodule

// File: rtl/coriolis_ker1_xn_ostream.sv
// Output stage for the xn_s0 stream: elastic buffer, per-run element count, completion.
// Optional checksum accumulator enabled by macro CORIOLIS_XN_OSTREAM_CHKSUM_EN.
module coriolis_ker1_xn_ostream
  import coriolis_pkg::*;
#(
  parameter int unsigned STREAMW = STREAMW_DEFAULT,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNTW    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNTW-1:0]    nelems,
  input  logic               ivalid_xn_s0,
  input  logic [STREAMW-1:0] xn_s0,
  output logic               iready,
  output logic               ovalid,
  output logic [STREAMW-1:0] odata,
  input  logic               oready,
  output logic               busy,
  output logic               done,
  output logic [CNTW-1:0]    wcount,
  output logic [31:0]        chksum
);

  ostream_state_t  state;
  logic [CNTW-1:0] nelems_q;
  logic [CNTW-1:0] acount;
  logic [CNTW-1:0] acount_nxt;
  logic [CNTW-1:0] wcount_nxt;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            start_ok;

  coriolis_sync_fifo #(
    .WIDTH (STREAMW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (xn_s0),
    .pop   (pop),
    .dout  (odata),
    .full  (full),
    .empty (empty)
  );

  // Handshake and status decode, all from registered state.
  assign iready     = (state == ST_RUN) & ~full & (acount < nelems_q);
  assign push       = ivalid_xn_s0 & iready;
  assign ovalid     = ~empty;
  assign pop        = ovalid & oready;
  assign busy       = (state == ST_RUN) | (state == ST_DRAIN);
  assign done       = (state == ST_DONE);
  assign start_ok   = start & ((state == ST_IDLE) | (state == ST_DONE));
  assign acount_nxt = acount + CNTW'(push);
  assign wcount_nxt = wcount + CNTW'(pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      nelems_q <= '0;
      acount   <= '0;
      wcount   <= '0;
    end else begin
      acount <= acount_nxt;
      wcount <= wcount_nxt;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            nelems_q <= nelems;
            acount   <= '0;
            wcount   <= '0;
            state    <= (nelems == CNTW'(0)) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (acount_nxt == nelems_q) state <= ST_DRAIN;
        end
        // Finish on the edge of the last output transfer so done follows it by one cycle.
        ST_DRAIN: begin
          if (wcount_nxt == nelems_q) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CORIOLIS_XN_OSTREAM_CHKSUM_EN
  logic [31:0] chksum_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      chksum_q <= '0;
    end else if (start_ok) begin
      chksum_q <= '0;
    end else if (pop) begin
      chksum_q <= chksum_q + odata[31:0];
    end
  end

  assign chksum = chksum_q;
`else
  assign chksum = 32'd0;
`endif

endmodule

// File: doc/coriolis_ker1_xn_ostream.md
# coriolis_ker1_xn_ostream

Downstream output stage for the coriolis ker1 kernel top. Consumes the `xn_s0` result stream through a valid/ready handshake, buffers it in an elastic FIFO, and forwards it to the output memory-write port. Counts a programmed number of elements per run, then signals completion. It is the last stage between the kernel pipeline and the host-visible output buffer.

## Interface
Parameters:
- `STREAMW`, 34, stream word width; matches the kernel stream width.
- `DEPTH`, 4, FIFO depth; a power of two, ≥ 2.
- `CNTW`, 32, element-counter width.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle run start; sampled in IDLE or DONE.
- `nelems`  in  CNTW  number of elements per run; latched on accepted `start`.
- `ivalid_xn_s0`  in  1  kernel output valid.
- `xn_s0`  in  STREAMW  kernel output data.
- `iready`  out  1  ready to the kernel; drives the kernel's `oready_xn_s0`.
- `ovalid`  out  1  write-port data valid.
- `odata`  out  STREAMW  write-port data.
- `oready`  in  1  write-port ready.
- `busy`  out  1  high in RUN or DRAIN.
- `done`  out  1  high in DONE.
- `wcount`  out  CNTW  elements delivered downstream this run.
- `chksum`  out  32  running checksum (see Configuration).

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `start`, with `nelems` latched. If `nelems == 0`, IDLE → DONE instead.
  - RUN → DRAIN when the accepted count reaches `nelems`.
  - DRAIN → DONE when the FIFO is empty and `wcount == nelems`.
  - DONE → RUN (or DONE if `nelems == 0`) on `start`; otherwise DONE holds.
- `start` is ignored in RUN and DRAIN.
- Input transfer occurs when `ivalid_xn_s0 & iready` are both high.
- `iready = (state == RUN) & ~full & (acount < nelems_q)`.
  - Derived from registered state only.
  - No push is allowed into a full FIFO, even in a cycle where a pop also occurs.
- Output transfer occurs when `ovalid & oready` are both high.
- `ovalid` is high whenever the FIFO is non-empty, in any state.
- `odata` is the FIFO head. It must stay stable while `ovalid & ~oready`.
- `acount` counts accepts. `wcount` counts output transfers. Both clear on an accepted `start`.
- Counters do not wrap within a run, because `iready` caps accepts at `nelems_q`.
- Data passes through unmodified; there is no width conversion.

## Timing
- Reset (`rst == 0` at a clock edge):
  - state = IDLE; FIFO flushed.
  - `iready = 0`, `ovalid = 0`, `busy = 0`, `done = 0`, `wcount = 0`, `chksum = 0`.
- Reset asserted mid-run aborts the run. Buffered data is discarded, and no partial `done` is produced.
- Latency: a word accepted at edge N appears on `odata` with `ovalid` high after edge N (first-word fall-through registered head). Minimum latency is one cycle.
- Throughput: one word per cycle sustained while `oready` is held high, for any `DEPTH ≥ 2`.
- Backpressure:
  - With `oready` low, at most `DEPTH` words are accepted.
  - `iready` drops in the cycle after the FIFO becomes full.
- `done` rises exactly one cycle after the last output transfer.

## Configuration
- Macro `CORIOLIS_XN_OSTREAM_CHKSUM_EN`.
- Defined: `chksum` accumulates `odata[31:0]` on every output transfer (sum modulo 2^32). It clears on an accepted `start` and on reset, and it is held in DONE.
- Undefined: `chksum` is tied to 0 and no accumulator logic is generated.
- The port list is identical in both cases.

## Structure
- Shared package `coriolis_pkg` holds:
  - the `STREAMW` default constant (34);
  - the FSM state typedef `ostream_state_t` (IDLE/RUN/DRAIN/DONE).
- Sub-module `coriolis_sync_fifo`: a parameterised synchronous FIFO.
  - Registered head, `full`/`empty` flags, active-low synchronous reset.
  - Reusable by other kernel output stages.
- The top level contains the FSM, the counters and the checksum.

## Test plan
- Basic run: `nelems = 8`, input words 1..8 back-to-back, `oready = 1` → `odata` = 1..8 in order, one per cycle; `done` rises one cycle after the 8th transfer; `wcount = 8`; `chksum = 36` when enabled.
- Backpressure: `DEPTH = 4`, `nelems = 10`, `oready = 0` for 10 cycles → exactly 4 accepts, `iready = 0` afterwards. After releasing `oready`, all 10 words arrive in order with no loss or duplication.
- Zero length: `nelems = 0`, pulse `start` → DONE on the next cycle; `iready` never asserts; `wcount = 0`.
- Excess input: `nelems = 3`, `ivalid_xn_s0` held high with 5 words available → only 3 accepted; `iready` low from the cycle after the third accept.
- Reset mid-run: assert `rst = 0` for one cycle after 2 of 6 words → all outputs at reset values; FIFO empty. A new `start` with `nelems = 2` completes normally with `wcount = 2`.
- Restart from DONE: a second `start` with `nelems = 4` → counters and `chksum` cleared, and the run completes with `wcount = 4`.
